// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: XLEN, branch FUNCT3 codes
// and the execute/memory stage FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [0:0] ex_state_t;

  localparam ex_state_t ST_RUN    = 1'b0;
  localparam ex_state_t ST_SQUASH = 1'b1;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from ALU flags; signed and unsigned
// compares both arrive on SLTU_SIG from the ALU.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] FUNCT3,
  input  logic       ZERO_SIG,
  input  logic       SLTU_SIG,
  output logic       TAKEN
);

  always_comb begin
    TAKEN = 1'b0;
    unique case (FUNCT3)
      F3_BEQ:  TAKEN = ZERO_SIG;
      F3_BNE:  TAKEN = ~ZERO_SIG;
      F3_BLT:  TAKEN = SLTU_SIG;
      F3_BGE:  TAKEN = ~SLTU_SIG;
      F3_BLTU: TAKEN = SLTU_SIG;
      F3_BGEU: TAKEN = ~SLTU_SIG;
      default: TAKEN = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with redirect and squash of younger ops.
// Optional EX_MEM_MISALIGN_TRAP_EN adds TRAP_MISALIGN output.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] ALU_RESULT,
  input  logic            ZERO_SIG,
  input  logic            SLTU_SIG,
  input  logic            IS_BRANCH,
  input  logic            IS_JUMP,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] TARGET,
  input  logic [XLEN-1:0] PC_PLUS4,
  input  logic [XLEN-1:0] STORE_DATA,
  input  logic [4:0]      RD_ADDR,
  input  logic            REG_WRITE,
  input  logic            MEM_READ,
  input  logic            MEM_WRITE,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_RESULT,
  output logic [XLEN-1:0] OUT_STORE_DATA,
  output logic [4:0]      OUT_RD_ADDR,
  output logic            OUT_REG_WRITE,
  output logic            OUT_MEM_READ,
  output logic            OUT_MEM_WRITE,
`ifdef EX_MEM_MISALIGN_TRAP_EN
  output logic            TRAP_MISALIGN,
`endif
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC
);

  ex_state_t       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            mr_q, mr_d;
  logic            mw_q, mw_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            trap_q, trap_d;

  logic br_taken;
  logic accept;
  logic ctl_xfer;
  logic br_only;
  logic misalign;

  branch_cond u_branch_cond (
    .FUNCT3   (FUNCT3),
    .ZERO_SIG (ZERO_SIG),
    .SLTU_SIG (SLTU_SIG),
    .TAKEN    (br_taken)
  );

  assign IN_READY = (state_q == ST_SQUASH) |
                    ~out_valid_q | OUT_READY;
  assign accept   = IN_VALID & IN_READY;
  assign br_only  = IS_BRANCH & ~IS_JUMP;
  assign ctl_xfer = IS_JUMP | (IS_BRANCH & br_taken);

`ifdef EX_MEM_MISALIGN_TRAP_EN
  assign misalign = |TARGET[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    mr_d        = mr_q;
    mw_d        = mw_q;
    redir_d     = 1'b0;
    rpc_d       = rpc_q;
    trap_d      = 1'b0;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == ST_SQUASH) begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end
      end else begin
        out_valid_d = 1'b1;
        result_d    = IS_JUMP ? PC_PLUS4 : ALU_RESULT;
        sdata_d     = STORE_DATA;
        rd_d        = RD_ADDR;
        rw_d        = REG_WRITE & ~br_only;
        mr_d        = MEM_READ & ~br_only;
        mw_d        = MEM_WRITE & ~br_only;
        if (ctl_xfer) begin
          state_d = ST_SQUASH;
          cnt_d   = 2'(SQUASH_DEPTH);
          if (misalign) begin
            // Trap replaces the redirect; the op must not commit.
            trap_d = 1'b1;
            rw_d   = 1'b0;
            mr_d   = 1'b0;
            mw_d   = 1'b0;
          end else begin
            redir_d = 1'b1;
            rpc_d   = TARGET;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sdata_q     <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      redir_q     <= 1'b0;
      rpc_q       <= '0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      redir_q     <= redir_d;
      rpc_q       <= rpc_d;
      trap_q      <= trap_d;
    end
  end

  assign OUT_VALID      = out_valid_q;
  assign OUT_RESULT     = result_q;
  assign OUT_STORE_DATA = sdata_q;
  assign OUT_RD_ADDR    = rd_q;
  assign OUT_REG_WRITE  = rw_q;
  assign OUT_MEM_READ   = mr_q;
  assign OUT_MEM_WRITE  = mw_q;
  assign REDIRECT       = redir_q;
  assign REDIRECT_PC    = rpc_q;
`ifdef EX_MEM_MISALIGN_TRAP_EN
  assign TRAP_MISALIGN  = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomised and directed bench for ex_mem_stage against
// a behavioural model of the EX->MEM handoff.
module tb_ex_mem_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        RESET, IN_VALID, IN_READY;
  logic [31:0] ALU_RESULT, TARGET, PC_PLUS4, STORE_DATA;
  logic        ZERO_SIG, SLTU_SIG, IS_BRANCH, IS_JUMP;
  logic [2:0]  FUNCT3;
  logic [4:0]  RD_ADDR;
  logic        REG_WRITE, MEM_READ, MEM_WRITE;
  logic        OUT_VALID, OUT_READY;
  logic [31:0] OUT_RESULT, OUT_STORE_DATA, REDIRECT_PC;
  logic [4:0]  OUT_RD_ADDR;
  logic        OUT_REG_WRITE, OUT_MEM_READ, OUT_MEM_WRITE;
  logic        REDIRECT;
  logic        trap_w;

  always #5 clk = ~clk;

  ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_RESULT(ALU_RESULT), .ZERO_SIG(ZERO_SIG),
    .SLTU_SIG(SLTU_SIG), .IS_BRANCH(IS_BRANCH),
    .IS_JUMP(IS_JUMP), .FUNCT3(FUNCT3),
    .TARGET(TARGET), .PC_PLUS4(PC_PLUS4),
    .STORE_DATA(STORE_DATA), .RD_ADDR(RD_ADDR),
    .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RESULT(OUT_RESULT),
    .OUT_STORE_DATA(OUT_STORE_DATA),
    .OUT_RD_ADDR(OUT_RD_ADDR),
    .OUT_REG_WRITE(OUT_REG_WRITE),
    .OUT_MEM_READ(OUT_MEM_READ),
    .OUT_MEM_WRITE(OUT_MEM_WRITE),
`ifdef EX_MEM_MISALIGN_TRAP_EN
    .TRAP_MISALIGN(trap_w),
`endif
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );

`ifndef EX_MEM_MISALIGN_TRAP_EN
  assign trap_w = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // model of what the memory stage should see
  bit        m_valid;
  bit [31:0] m_res, m_sd, m_rpc;
  bit [4:0]  m_rd;
  bit        m_rw, m_mr, m_mw, m_redir, m_trap;
  int        m_drops;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit taken(input bit [2:0] f3,
                               input bit z, input bit lt);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit acc, xfer, bad;
    acc = IN_VALID && ((m_drops > 0) || !m_valid || OUT_READY);
    if (RESET) begin
      m_valid = 0; m_res = 0; m_sd = 0; m_rd = 0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_redir = 0;
      m_rpc = 0; m_trap = 0; m_drops = 0;
      return;
    end
    m_redir = 0;
    m_trap  = 0;
    if (m_valid && OUT_READY) m_valid = 0;
    if (!acc) return;
    if (m_drops > 0) begin
      m_drops--;
      return;
    end
    m_valid = 1;
    m_res = IS_JUMP ? PC_PLUS4 : ALU_RESULT;
    m_sd  = STORE_DATA;
    m_rd  = RD_ADDR;
    m_rw  = REG_WRITE && (IS_JUMP || !IS_BRANCH);
    m_mr  = MEM_READ && (IS_JUMP || !IS_BRANCH);
    m_mw  = MEM_WRITE && (IS_JUMP || !IS_BRANCH);
    xfer = IS_JUMP ||
           (IS_BRANCH && taken(FUNCT3, ZERO_SIG, SLTU_SIG));
    if (!xfer) return;
    m_drops = DEPTH;
`ifdef EX_MEM_MISALIGN_TRAP_EN
    bad = (TARGET % 4) != 0;
`else
    bad = 0;
`endif
    if (bad) begin
      m_trap = 1;
      m_rw = 0; m_mr = 0; m_mw = 0;
    end else begin
      m_redir = 1;
      m_rpc = TARGET;
    end
  endtask

  // inputs are set right after a negedge; one clock per call
  task automatic cyc();
    #1;
    if (!RESET)
      chk("in_ready", IN_READY,
          32'((m_drops > 0) || !m_valid || OUT_READY));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("out_valid", OUT_VALID, 32'(m_valid));
    chk("redirect", REDIRECT, 32'(m_redir));
    chk("redirect_pc", REDIRECT_PC, m_rpc);
    chk("trap", trap_w, 32'(m_trap));
    chk("out_result", OUT_RESULT, m_res);
    chk("out_sdata", OUT_STORE_DATA, m_sd);
    chk("out_rd", OUT_RD_ADDR, 32'(m_rd));
    chk("out_ctl", {OUT_REG_WRITE, OUT_MEM_READ,
                    OUT_MEM_WRITE},
        32'({m_rw, m_mr, m_mw}));
  endtask

  task automatic idle();
    IN_VALID = 0; ALU_RESULT = 0; ZERO_SIG = 0;
    SLTU_SIG = 0; IS_BRANCH = 0; IS_JUMP = 0;
    FUNCT3 = 0; TARGET = 0; PC_PLUS4 = 0;
    STORE_DATA = 0; RD_ADDR = 0; REG_WRITE = 0;
    MEM_READ = 0; MEM_WRITE = 0;
  endtask

  task automatic alu(input logic [31:0] r);
    idle();
    IN_VALID = 1; ALU_RESULT = r; STORE_DATA = ~r;
    RD_ADDR = r[4:0]; REG_WRITE = 1;
  endtask

  task automatic jal(input logic [31:0] tgt);
    idle();
    IN_VALID = 1; IS_JUMP = 1; TARGET = tgt;
    PC_PLUS4 = 32'h8; RD_ADDR = 5'd1; REG_WRITE = 1;
    ALU_RESULT = 32'hdead_0000;
  endtask

  initial begin
    idle();
    RESET = 1; OUT_READY = 1;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_valid", OUT_VALID, 32'h0);
    chk("rst_rpc", REDIRECT_PC, 32'h0);
    RESET = 0;

    // streaming
    for (int i = 1; i <= 4; i++) begin
      alu(32'h11 * i);
      cyc();
      chk("stream_res", OUT_RESULT, 32'h11 * i);
      chk("stream_vld", OUT_VALID, 32'h1);
    end

    // stall with 0x1234 held
    alu(32'h1234); cyc();
    alu(32'h5555); OUT_READY = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_res", OUT_RESULT, 32'h1234);
      chk("stall_rdy", IN_READY, 32'h0);
    end
    OUT_READY = 1; cyc();
    chk("resume_res", OUT_RESULT, 32'h5555);

    // BEQ taken
    idle(); IN_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'b000;
    ZERO_SIG = 1; TARGET = 32'h100; REG_WRITE = 1;
    cyc();
    chk("beq_redir", REDIRECT, 32'h1);
    chk("beq_rpc", REDIRECT_PC, 32'h100);
    chk("beq_rw", OUT_REG_WRITE, 32'h0);
    alu(32'ha1); cyc();
    chk("beq_pulse", REDIRECT, 32'h0);
    alu(32'ha2); cyc();
    alu(32'ha3); cyc();
    chk("beq_fwd", OUT_RESULT, 32'ha3);

    // BGEU not taken
    idle(); IN_VALID = 1; IS_BRANCH = 1; FUNCT3 = 3'b111;
    SLTU_SIG = 1; TARGET = 32'h200; ALU_RESULT = 32'h1;
    cyc();
    chk("bgeu_redir", REDIRECT, 32'h0);
    alu(32'hb1); cyc();
    chk("bgeu_fwd", OUT_RESULT, 32'hb1);

    // JAL
    jal(32'h300); cyc();
    chk("jal_res", OUT_RESULT, 32'h8);
    chk("jal_rw", OUT_REG_WRITE, 32'h1);
    chk("jal_redir", REDIRECT, 32'h1);

    // reset with one drop left
    alu(32'hc1); cyc();
    alu(32'hc2); RESET = 1; cyc();
    chk("rsq_valid", OUT_VALID, 32'h0);
    RESET = 0;
    alu(32'h77); cyc();
    chk("rsq_fwd", OUT_RESULT, 32'h77);
    chk("rsq_redir", REDIRECT, 32'h0);

`ifdef EX_MEM_MISALIGN_TRAP_EN
    jal(32'h102); cyc();
    chk("mis_trap", trap_w, 32'h1);
    chk("mis_redir", REDIRECT, 32'h0);
    chk("mis_rw", OUT_REG_WRITE, 32'h0);
`endif

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      idle();
      IN_VALID   = ($urandom_range(9) < 7);
      OUT_READY  = ($urandom_range(9) < 7);
      RESET      = ($urandom_range(99) < 2);
      ALU_RESULT = $urandom;
      ZERO_SIG   = 1'($urandom);
      SLTU_SIG   = 1'($urandom);
      IS_BRANCH  = ($urandom_range(3) == 0);
      IS_JUMP    = ($urandom_range(9) == 0);
      FUNCT3     = 3'($urandom);
      TARGET     = $urandom;
      if ($urandom_range(1) == 0) TARGET[1:0] = 2'b00;
      PC_PLUS4   = $urandom;
      STORE_DATA = $urandom;
      RD_ADDR    = 5'($urandom);
      REG_WRITE  = 1'($urandom);
      MEM_READ   = 1'($urandom);
      MEM_WRITE  = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
